// File: rtl/servo_ramp_ctrl.sv
// Servo position ramp controller: round-robin target requests from A/B, pos slewed by at most STEP per frame.
// Optional SERVO_SWEEP_EN adds sweep_en for a continuous 0<->POS_MAX sweep when no request is granted.
module servo_ramp_ctrl #(
   parameter int FRAME_CYCLES = 2000000,
   parameter int STEP         = 10,
   parameter int POS_MAX      = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef SERVO_SWEEP_EN
   input  logic       sweep_en,
`endif
   input  logic       a_valid,
   input  logic [9:0] a_pos,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [9:0] b_pos,
   output logic       b_ready,
   output logic [9:0] pos,
   output logic       frame_tick,
   output logic       busy
);

   localparam int              CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [9:0]      PMAX     = 10'(POS_MAX);
   localparam logic [10:0]     STEP_W   = 11'(STEP);

   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          rr_q;
   logic [9:0]    pos_q, pos_d;
   logic [9:0]    tgt_q, tgt_d;
   state_t        state_q, state_d;
   logic          grant_a, grant_b;
   logic [9:0]    req_pos, req_clamped;
   logic [10:0]   diff, step_amt;

   // rr_q set means B is favoured when both request
   assign grant_a    = rst_n & a_valid & (~b_valid | ~rr_q);
   assign grant_b    = rst_n & b_valid & (~a_valid | rr_q);
   assign a_ready    = grant_a;
   assign b_ready    = grant_b;
   assign frame_tick = (cnt_q == CNT_LAST);
   assign pos        = pos_q;
   assign busy       = (pos_q != tgt_q);

   assign req_pos     = grant_a ? a_pos : b_pos;
   assign req_clamped = (req_pos > PMAX) ? PMAX : req_pos;

   always_comb begin
      cnt_d = frame_tick ? '0 : cnt_q + CW'(1);

      // 11-bit difference keeps the subtraction from wrapping in either direction
      diff = (state_q == RAMP_DOWN) ? ({1'b0, pos_q} - {1'b0, tgt_q})
                                    : ({1'b0, tgt_q} - {1'b0, pos_q});
      step_amt = (diff > STEP_W) ? STEP_W : diff;

      pos_d = pos_q;
      if (frame_tick) begin
         case (state_q)
            RAMP_UP:   pos_d = pos_q + step_amt[9:0];
            RAMP_DOWN: pos_d = pos_q - step_amt[9:0];
            default:   pos_d = pos_q;
         endcase
      end

      tgt_d = tgt_q;
      if (grant_a | grant_b)
         tgt_d = req_clamped;
`ifdef SERVO_SWEEP_EN
      else if (sweep_en && state_q == IDLE)
         tgt_d = (pos_q == 10'd0) ? PMAX : 10'd0;
`endif

      if (pos_d == tgt_d)     state_d = IDLE;
      else if (pos_d < tgt_d) state_d = RAMP_UP;
      else                    state_d = RAMP_DOWN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         rr_q    <= 1'b0;
         pos_q   <= 10'd0;
         tgt_q   <= 10'd0;
         state_q <= IDLE;
      end else begin
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         state_q <= state_d;
         if (grant_a)      rr_q <= 1'b1;
         else if (grant_b) rr_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with FRAME_CYCLES=20; sweep scenario built when SERVO_SWEEP_EN is defined.
module tb_servo_ramp_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid;
   logic [9:0] a_pos, b_pos;
   logic       a_ready, b_ready;
   logic [9:0] pos;
   logic       frame_tick, busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   servo_ramp_ctrl #(.FRAME_CYCLES(20), .STEP(10), .POS_MAX(1000)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SERVO_SWEEP_EN
      .sweep_en  (1'b0),
`endif
      .a_valid   (a_valid),
      .a_pos     (a_pos),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_pos     (b_pos),
      .b_ready   (b_ready),
      .pos       (pos),
      .frame_tick(frame_tick),
      .busy      (busy)
   );

`ifdef SERVO_SWEEP_EN
   logic       s_rst_n = 1'b0;
   logic       s_sweep = 1'b1;
   logic       s_a_valid = 1'b0;
   logic [9:0] s_a_pos = 10'd0;
   logic       s_a_ready, s_b_ready, s_tick, s_busy;
   logic [9:0] s_pos;

   servo_ramp_ctrl #(.FRAME_CYCLES(20), .STEP(250), .POS_MAX(1000)) u_sw (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .sweep_en  (s_sweep),
      .a_valid   (s_a_valid),
      .a_pos     (s_a_pos),
      .a_ready   (s_a_ready),
      .b_valid   (1'b0),
      .b_pos     (10'd0),
      .b_ready   (s_b_ready),
      .pos       (s_pos),
      .frame_tick(s_tick),
      .busy      (s_busy)
   );
`endif

   // Stops on the negedge of a tick cycle; n counts negedges waited (200 on timeout)
   task automatic wait_tick_neg(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (frame_tick) break;
      end
   endtask

   task automatic wait_tick();
      int n;
      wait_tick_neg(n);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_pos = 10'd5; b_pos = 10'd6;
      #2;
      n_cmp++; if (pos !== 10'd0)    begin n_bad++; $display("FAIL reset_pos: got %0d want 0", pos); end
      n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
      n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
         begin n_bad++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_tick_neg(n);
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL first_tick: got %0d cycles want 20", n); end
      @(posedge clk); #1;
      wait_tick_neg(n);
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL tick_period: got %0d cycles want 20", n); end
      n_cmp++; if (pos !== 10'd0 || busy !== 1'b0)
         begin n_bad++; $display("FAIL idle_hold: got pos=%0d busy=%b want 0 0", pos, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_ramp_up();
      int exp_up[4] = '{10, 20, 30, 35};
      a_valid = 1'b1; a_pos = 10'd35;
      #1;
      n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
         begin n_bad++; $display("FAIL up_grant: got a=%b b=%b want 1 0", a_ready, b_ready); end
      @(posedge clk); #1;
      a_valid = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b1 || pos !== 10'd0)
         begin n_bad++; $display("FAIL up_busy: got busy=%b pos=%0d want 1 0", busy, pos); end
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         n_cmp++; if (pos !== 10'(exp_up[i]))
            begin n_bad++; $display("FAIL up_step%0d: got %0d want %0d", i, pos, exp_up[i]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL up_done_busy: got %b want 0", busy); end
   endtask

   task automatic test_arbitration();
      logic ea;
      wait_tick();
      b_valid = 1'b1; b_pos = 10'd35;
      #1;
      n_cmp++; if (b_ready !== 1'b1 || a_ready !== 1'b0)
         begin n_bad++; $display("FAIL arb_b_alone: got a=%b b=%b want 0 1", a_ready, b_ready); end
      @(posedge clk); #1;
      a_valid = 1'b1; a_pos = 10'd20; b_pos = 10'd60;
      for (int i = 0; i < 4; i++) begin
         ea = (i % 2 == 0);
         #1;
         n_cmp++; if (a_ready !== ea || b_ready !== ~ea)
            begin n_bad++; $display("FAIL arb_rr%0d: got a=%b b=%b want %b %b", i, a_ready, b_ready, ea, ~ea); end
         @(posedge clk); #1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      wait_tick();
      n_cmp++; if (pos !== 10'd45) begin n_bad++; $display("FAIL arb_final_target: got pos %0d want 45", pos); end
      wait_tick();
      wait_tick();
      n_cmp++; if (pos !== 10'd60 || busy !== 1'b0)
         begin n_bad++; $display("FAIL arb_settle: got pos=%0d busy=%b want 60 0", pos, busy); end
   endtask

   task automatic test_clamp();
      int max_seen = 0;
      int bad_steps = 0;
      int prev;
      a_valid = 1'b1; a_pos = 10'd1023;
      @(posedge clk); #1;
      a_valid = 1'b0;
      prev = int'(pos);
      for (int i = 0; i < 100; i++) begin
         wait_tick();
         if (int'(pos) > max_seen) max_seen = int'(pos);
         if (int'(pos) - prev > 10 || int'(pos) < prev) bad_steps++;
         prev = int'(pos);
      end
      n_cmp++; if (max_seen !== 1000) begin n_bad++; $display("FAIL clamp_max: got %0d want 1000", max_seen); end
      n_cmp++; if (pos !== 10'd1000 || busy !== 1'b0)
         begin n_bad++; $display("FAIL clamp_final: got pos=%0d busy=%b want 1000 0", pos, busy); end
      n_cmp++; if (bad_steps !== 0) begin n_bad++; $display("FAIL clamp_slew: got %0d bad steps want 0", bad_steps); end
   endtask

   task automatic test_reset_mid_ramp();
      int n;
      a_valid = 1'b1; a_pos = 10'd0;
      @(posedge clk); #1;
      a_valid = 1'b0;
      wait_tick();
      wait_tick();
      n_cmp++; if (pos !== 10'd980) begin n_bad++; $display("FAIL down_ramp: got %0d want 980", pos); end
      @(negedge clk); #2;
      a_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (pos !== 10'd0 || busy !== 1'b0 || a_ready !== 1'b0)
         begin n_bad++; $display("FAIL midreset: got pos=%0d busy=%b a_ready=%b want 0 0 0", pos, busy, a_ready); end
      @(posedge clk); #1;
      a_valid = 1'b0;
      rst_n = 1'b1;
      wait_tick_neg(n);
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL midreset_tick: got %0d cycles want 20", n); end
      @(posedge clk); #1;
      n_cmp++; if (pos !== 10'd0) begin n_bad++; $display("FAIL midreset_pos: got %0d want 0", pos); end
   endtask

   task automatic test_reverse();
      a_valid = 1'b1; a_pos = 10'd600;
      @(posedge clk); #1;
      a_valid = 1'b0;
      for (int i = 0; i < 50; i++) wait_tick();
      n_cmp++; if (pos !== 10'd500 || busy !== 1'b1)
         begin n_bad++; $display("FAIL rev_mid: got pos=%0d busy=%b want 500 1", pos, busy); end
      a_valid = 1'b1; a_pos = 10'd480;
      @(posedge clk); #1;
      a_valid = 1'b0;
      wait_tick();
      n_cmp++; if (pos !== 10'd490) begin n_bad++; $display("FAIL rev_step1: got %0d want 490", pos); end
      wait_tick();
      n_cmp++; if (pos !== 10'd480 || busy !== 1'b0)
         begin n_bad++; $display("FAIL rev_step2: got pos=%0d busy=%b want 480 0", pos, busy); end
   endtask

   task automatic test_grant_on_tick();
      int n;
      a_valid = 1'b1; a_pos = 10'd600;
      @(posedge clk); #1;
      a_valid = 1'b0;
      wait_tick();
      n_cmp++; if (pos !== 10'd490) begin n_bad++; $display("FAIL tickgrant_pre: got %0d want 490", pos); end
      wait_tick_neg(n);
      a_valid = 1'b1; a_pos = 10'd300;
      #1;
      n_cmp++; if (a_ready !== 1'b1 || frame_tick !== 1'b1)
         begin n_bad++; $display("FAIL tickgrant_ready: got a_ready=%b tick=%b want 1 1", a_ready, frame_tick); end
      @(posedge clk); #1;
      a_valid = 1'b0;
      n_cmp++; if (pos !== 10'd500) begin n_bad++; $display("FAIL tickgrant_old: got %0d want 500", pos); end
      wait_tick();
      n_cmp++; if (pos !== 10'd490) begin n_bad++; $display("FAIL tickgrant_new: got %0d want 490", pos); end
   endtask

`ifdef SERVO_SWEEP_EN
   task automatic wait_s_tick();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_tick) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      int exp_sw[9] = '{250, 500, 750, 1000, 750, 500, 250, 0, 250};
      @(posedge clk); #1;
      s_rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wait_s_tick();
         n_cmp++; if (s_pos !== 10'(exp_sw[i]))
            begin n_bad++; $display("FAIL sweep%0d: got %0d want %0d", i, s_pos, exp_sw[i]); end
      end
      s_a_valid = 1'b1; s_a_pos = 10'd300;
      @(posedge clk); #1;
      s_a_valid = 1'b0;
      wait_s_tick();
      n_cmp++; if (s_pos !== 10'd300) begin n_bad++; $display("FAIL sweep_req: got %0d want 300", s_pos); end
      wait_s_tick();
      n_cmp++; if (s_pos !== 10'd50) begin n_bad++; $display("FAIL sweep_resume: got %0d want 50", s_pos); end
   endtask
`endif

   initial begin
      test_reset();
      test_ramp_up();
      test_arbitration();
      test_clamp();
      test_reset_mid_ramp();
      test_reverse();
      test_grant_on_tick();
`ifdef SERVO_SWEEP_EN
      test_sweep();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 2000000, clk cycles per 20 ms servo frame.
REQ-002 SHALL have parameter STEP, default 10, maximum pos change per frame.
REQ-003 SHALL have parameter POS_MAX, default 1000, upper limit of pos.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port a_valid  input  1  requester A target request.
REQ-007 SHALL have port a_pos  input  10  requester A target position.
REQ-008 SHALL have port a_ready  output  1  requester A grant; transfer when a_valid&a_ready.
REQ-009 SHALL have ports b_valid, b_pos, b_ready  with the same widths and meaning as A, for requester B.
REQ-010 SHALL have port pos  output  10  commanded position, fed to the servo PWM generator.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-012 SHALL have port busy  output  1  high while pos != target.

Function
REQ-013 SHALL run a frame counter 0..FRAME_CYCLES-1, wrapping to 0; frame_tick high exactly in the cycle the counter equals FRAME_CYCLES-1.
REQ-014 SHALL arbitrate A/B round-robin: if one valid, it is granted; if both valid, grant the requester not granted last; at most one grant per cycle.
REQ-015 SHALL drive a_ready/b_ready combinationally as the grant, so a non-granted valid request waits, holding its data.
REQ-016 SHALL load target on a grant in the following cycle, clamped: values above POS_MAX load as POS_MAX.
REQ-017 SHALL implement states IDLE (pos==target), RAMP_UP (pos<target), RAMP_DOWN (pos>target), re-evaluated every cycle from pos and target.
REQ-018 SHALL update pos only on frame_tick: RAMP_UP pos += min(STEP, target-pos); RAMP_DOWN pos -= min(STEP, pos-target); IDLE unchanged.
REQ-019 SHALL never overshoot target, never exceed POS_MAX, never underflow below 0 (11-bit internal difference).
REQ-020 SHALL, on a grant coinciding with frame_tick, step pos toward the old target; the new target takes effect at the next frame.
REQ-021 SHALL allow target changes mid-ramp, including reversing direction, with no pos discontinuity beyond STEP per frame.
REQ-022 SHALL assert busy combinationally from pos != target.

Reset
REQ-023 SHALL, on rst_n low, immediately set pos=0, target=0, frame counter=0, frame_tick=0, round-robin pointer to favour A, state IDLE.
REQ-024 SHALL hold a_ready and b_ready low while rst_n is low.
REQ-025 SHALL, on reset assertion mid-ramp, abandon the ramp; the first frame_tick after release occurs FRAME_CYCLES cycles after release.

Configuration
REQ-026 SHALL, when SERVO_SWEEP_EN is defined, add input sweep_en (1 bit): while sweep_en high and no request granted, on reaching target (IDLE) the block loads target=POS_MAX if pos==0, else target=0, producing a continuous 0<->POS_MAX sweep.
REQ-027 SHALL give granted requests priority over sweep reloads in the same cycle.
REQ-028 SHALL, when SERVO_SWEEP_EN is undefined, omit sweep_en and all sweep logic; target changes only via requests.

Verification (FRAME_CYCLES=20 for simulation)
REQ-029 Reset release, no requests -> pos=0, busy=0, frame_tick pulses every 20 cycles, first 20 cycles after release.
REQ-030 A requests 35 -> a_ready same cycle; busy=1; pos 10,20,30,35 on four successive frame_ticks; then busy=0.
REQ-031 A and B both valid for 4 cycles (pointer favouring A) -> grants A,B,A,B; final target = B's data.
REQ-032 Request 1023 -> target clamps to 1000; pos stops at 1000, never exceeds it.
REQ-033 Ramping up at pos=500, request 480 -> pos 490, 480 on next two ticks; grant in a frame_tick cycle -> that tick steps toward old target.
REQ-034 SERVO_SWEEP_EN defined, sweep_en=1, STEP=250 -> pos 250,500,750,1000,750,...,0,250; A request 300 mid-sweep overrides target.
